// File: rtl/proc_pkg.sv
// Shared types and constants for the lab9 multicycle control sequencer.
package proc_pkg;

    localparam int          NUM_REGS    = 8;
    localparam logic [3:0]  MUX_SEL_IMM = 4'b1000;

    typedef enum logic [3:0] {
        OP_MVI = 4'd0,
        OP_MOV = 4'd1,
        OP_ADD = 4'd2,
        OP_SUB = 4'd3,
        OP_AND = 4'd4,
        OP_OR  = 4'd5,
        OP_XOR = 4'd6
    } opcode_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_T3   = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4
    } alu_op_t;

    function automatic logic is_legal(input logic [3:0] op);
        return op <= OP_XOR;
    endfunction

    function automatic alu_op_t alu_of(input logic [3:0] op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_XOR:  return ALU_XOR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/proc_ctrl_reg_dec.sv
// 3-to-8 one-hot decoder with enable; turns the rx field into a register load enable.
module reg_dec (
    input  logic       en_i,
    input  logic [2:0] sel_i,
    output logic [7:0] dec_o
);

    always_comb begin
        dec_o = '0;
        if (en_i) begin
            dec_o[sel_i] = 1'b1;
        end
    end

endmodule

// File: rtl/proc_ctrl.sv
// Multicycle control sequencer: latches one instruction and steps T1..T3 then FIN.
// Optional macro INSTR_CNT_EN adds the instr_cnt completed-instruction counter.
module proc_ctrl #(
    parameter int         NUM_REGS = 8,
    parameter logic [3:0] IMM_SEL  = 4'b1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [15:0]          instr,
    output logic [3:0]           mux_sel,
    output logic [NUM_REGS-1:0]  reg_en,
    output logic                 a_en,
    output logic                 g_en,
    output logic [2:0]           alu_op,
    output logic                 wb_sel,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output proc_pkg::state_t     dbg_state_o
`ifdef INSTR_CNT_EN
    ,
    output logic [15:0]          instr_cnt
`endif
);

    import proc_pkg::*;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic        dec_en;
    logic [3:0]  opcode;
    logic [2:0]  rx, ry;

    assign opcode = ir_q[15:12];
    assign rx     = ir_q[11:9];
    assign ry     = ir_q[8:6];

    // start is a level request sampled only while IDLE; it is never queued,
    // so a request seen in any other state (including FIN) is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        mux_sel = 4'd0;
        dec_en  = 1'b0;
        a_en    = 1'b0;
        g_en    = 1'b0;
        alu_op  = ALU_ADD;
        wb_sel  = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ir_d    = instr;
                    state_d = S_T1;
                end
            end
            S_T1: begin
                state_d = S_FIN;
                case (opcode)
                    OP_MVI: begin
                        mux_sel = IMM_SEL;
                        dec_en  = 1'b1;
                    end
                    OP_MOV: begin
                        mux_sel = {1'b0, ry};
                        dec_en  = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        mux_sel = {1'b0, rx};
                        a_en    = 1'b1;
                        state_d = S_T2;
                    end
                    default: ;
                endcase
            end
            S_T2: begin
                mux_sel = {1'b0, ry};
                g_en    = 1'b1;
                alu_op  = alu_of(opcode);
                state_d = S_T3;
            end
            S_T3: begin
                wb_sel  = 1'b1;
                dec_en  = 1'b1;
                state_d = S_FIN;
            end
            S_FIN: begin
                done    = 1'b1;
                err     = !is_legal(opcode);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Destination is always rx; only MVI/MOV in T1 and ALU ops in T3 write.
    reg_dec u_reg_dec (
        .en_i  (dec_en),
        .sel_i (rx),
        .dec_o (reg_en)
    );

    assign busy        = (state_q != S_IDLE);
    assign dbg_state_o = state_q;

`ifdef INSTR_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    assign cnt_d = (state_q == S_FIN) ? cnt_q + 16'd1 : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign instr_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_proc_ctrl.sv
// Self-checking bench for proc_ctrl: directed plan steps plus random instructions
// compared cycle by cycle against a per-opcode reference of expected output vectors.
module tb_proc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] instr = '0;
    logic [3:0]  mux_sel;
    logic [7:0]  reg_en;
    logic        a_en, g_en, wb_sel, busy, done, err;
    logic [2:0]  alu_op;
    proc_pkg::state_t dbg_state;
`ifdef INSTR_CNT_EN
    logic [15:0] instr_cnt;
`endif

    int n_checks = 0;
    int n_fails  = 0;
    int exp_cnt  = 0;
    logic [20:0] exp_q[$];

    proc_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .instr       (instr),
        .mux_sel     (mux_sel),
        .reg_en      (reg_en),
        .a_en        (a_en),
        .g_en        (g_en),
        .alu_op      (alu_op),
        .wb_sel      (wb_sel),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .dbg_state_o (dbg_state)
`ifdef INSTR_CNT_EN
        ,
        .instr_cnt   (instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] pack(input logic [3:0] m, input logic [7:0] r,
                                         input logic a, input logic g, input logic [2:0] op,
                                         input logic wb, input logic b, input logic d,
                                         input logic e);
        return {m, r, a, g, op, wb, b, d, e};
    endfunction

    // Reference: the list of per-cycle output vectors following acceptance.
    function automatic void model(input logic [15:0] ins);
        int op, rx, ry;
        logic [7:0] oh;
        op = int'(ins[15:12]);
        rx = int'(ins[11:9]);
        ry = int'(ins[8:6]);
        oh = 8'd1 << rx;
        if (op == 0 || op == 1) begin
            exp_q.push_back(pack((op == 0) ? 4'd8 : 4'(ry), oh, 0, 0, 3'd0, 0, 1, 0, 0));
            exp_q.push_back(pack(4'd0, 8'd0, 0, 0, 3'd0, 0, 1, 1, 0));
        end else if (op >= 2 && op <= 6) begin
            exp_q.push_back(pack(4'(rx), 8'd0, 1, 0, 3'd0, 0, 1, 0, 0));
            exp_q.push_back(pack(4'(ry), 8'd0, 0, 1, 3'(op - 2), 0, 1, 0, 0));
            exp_q.push_back(pack(4'd0, oh, 0, 0, 3'd0, 1, 1, 0, 0));
            exp_q.push_back(pack(4'd0, 8'd0, 0, 0, 3'd0, 0, 1, 1, 0));
        end else begin
            exp_q.push_back(pack(4'd0, 8'd0, 0, 0, 3'd0, 0, 1, 0, 0));
            exp_q.push_back(pack(4'd0, 8'd0, 0, 0, 3'd0, 0, 1, 1, 1));
        end
    endfunction

    task automatic check(input string tag, input logic [20:0] expv);
        logic [20:0] obs;
        obs = {mux_sel, reg_en, a_en, g_en, alu_op, wb_sel, busy, done, err};
        n_checks++;
        assert (obs === expv) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_cnt(input string tag);
`ifdef INSTR_CNT_EN
        n_checks++;
        assert (instr_cnt === 16'(exp_cnt)) else begin
            n_fails++;
            $error("FAIL %s instr_cnt observed=%0d expected=%0d", tag, instr_cnt, exp_cnt);
        end
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    task automatic run(input logic [15:0] ins, input logic hold, input string tag);
        int n;
        @(negedge clk);
        start = 1'b1;
        instr = ins;
        model(ins);
        n = exp_q.size();
        @(posedge clk);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!hold) begin
                start = 1'b0;
                instr = 16'($urandom);
            end
            check($sformatf("%s_c%0d", tag, i + 1), exp_q.pop_front());
        end
        @(negedge clk);
        exp_cnt++;
        check($sformatf("%s_idle", tag), '0);
        check_cnt($sformatf("%s_cnt", tag));
        if (hold) begin
            model(ins);
            @(posedge clk);
            for (int i = 0; i < n; i++) begin
                @(negedge clk);
                start = 1'b0;
                check($sformatf("%s_re_c%0d", tag, i + 1), exp_q.pop_front());
            end
            @(negedge clk);
            exp_cnt++;
            check($sformatf("%s_re_idle", tag), '0);
            check_cnt($sformatf("%s_re_cnt", tag));
        end
    endtask

    initial begin
        logic [15:0] ins;
        #1;
        check("reset_async", '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("reset_release", '0);
        check_cnt("reset_cnt");

        run(16'h0A00, 1'b0, "mvi_r5");
        run(16'h15C0, 1'b0, "mov_r2_r7");
        run(16'h2300, 1'b0, "add_r1_r4");
        run(16'hF000, 1'b0, "illegal_f");
        run(16'h7E40, 1'b0, "illegal_7");
        run(16'h26C0, 1'b0, "add_r3_r3");
        run(16'h6A40, 1'b1, "xor_held");

        // Reset during T2 of SUB: outputs clear at once, nothing follows.
        @(negedge clk);
        start = 1'b1;
        instr = 16'h3A80;
        model(16'h3A80);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("sub_t1", exp_q.pop_front());
        @(negedge clk);
        check("sub_t2", exp_q.pop_front());
        exp_q.delete();
        #2;
        rst_n = 1'b0;
        #1;
        check("sub_abort_async", '0);
        exp_cnt = 0;
        check_cnt("abort_cnt");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("post_abort_c%0d", i), '0);
        end

        for (int k = 0; k < 30; k++) begin
            ins = {4'($urandom_range(0, 15)), 12'($urandom)};
            run(ins, ($urandom_range(0, 3) == 0), $sformatf("rnd%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
